// File: rtl/plic_mt_pkg.sv
// Shared address map, ID-width helper and the priority arbiter for plic_mt.
// The arbiter works on a fixed 64-ID space; callers pad unused IDs with zero.
package plic_mt_pkg;

  localparam logic [11:0] PRIO_BASE  = 12'h000;
  localparam logic [11:0] PEND_BASE  = 12'h100;
  localparam logic [11:0] EN_BASE    = 12'h200;
  localparam logic [11:0] EN_STRIDE  = 12'h020;
  localparam logic [11:0] CTX_BASE   = 12'h400;
  localparam logic [11:0] CTX_STRIDE = 12'h010;

  function automatic int idw(input int nsources);
    return $clog2(nsources + 1);
  endfunction

  // Highest priority wins; the strict compare on an ascending scan keeps the lowest ID on ties.
  function automatic logic [5:0] best_id(input logic [63:0] elig, input logic [63:0][7:0] prio);
    logic [5:0] id;
    logic [7:0] bp;
    id = '0;
    bp = '0;
    for (int i = 1; i < 64; i++) begin
      if (elig[i] && prio[i] > bp) begin
        id = 6'(i);
        bp = prio[i];
      end
    end
    return id;
  endfunction

endpackage

// File: rtl/plic_mt_gateway.sv
// Per-source gateway: level or edge capture into pending, claim moves it to in-flight.
// Pending is set one cycle after the qualifying input; claim clear beats a same-cycle set.
module plic_mt_gateway #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic src_i,
  input  logic claim_clr,
  input  logic complete_clr,
  output logic pending_o
);

  logic src_q;
  logic in_flight;
  logic trig;

  assign trig = (EDGE ? (src_i & ~src_q) : src_i) & ~pending_o & ~in_flight;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q     <= 1'b0;
      pending_o <= 1'b0;
      in_flight <= 1'b0;
    end else begin
      src_q <= src_i;
      if (claim_clr) begin
        pending_o <= 1'b0;
        in_flight <= 1'b1;
      end else begin
        if (trig)         pending_o <= 1'b1;
        if (complete_clr) in_flight <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/plic_mt.sv
// Multi-target PLIC: register file, per-target arbiters and word-bus decode.
// Bus answers every request exactly one cycle later, never stalls; ext_irq_o is registered.
module plic_mt
  import plic_mt_pkg::*;
#(
  parameter int                    NSOURCES  = 32,
  parameter int                    NTARGETS  = 2,
  parameter int                    PRIO_W    = 3,
  parameter logic [NSOURCES-1:0]   EDGE_MASK = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NSOURCES-1:0] src_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [11:0]         addr_i,
  input  logic [31:0]         wdata_i,
  output logic                rvalid_o,
  output logic [31:0]         rdata_o,
  output logic [NTARGETS-1:0] ext_irq_o
);

  localparam int IDW = idw(NSOURCES);
  localparam logic [63:0] ID_MASK = ((64'd1 << NSOURCES) - 64'd1) << 1;

  logic [63:0][PRIO_W-1:0]       prio_q;
  logic [NTARGETS-1:0][63:0]     en_q;
  logic [NTARGETS-1:0][PRIO_W-1:0] thr_q;
  logic [63:0]                   pend_ids;
  logic [63:0][7:0]              prio8;
  logic [NTARGETS-1:0][IDW-1:0]  best;

  logic                rd, wr, prio_hit;
  logic [NTARGETS-1:0] en_hit, thr_hit, ctx_hit;
  logic [31:0]         rd_dat;
  logic                claim_fire, cmp_fire;
  logic [IDW-1:0]      claim_id;
  logic [11:0]         eb, cb;

  for (genvar g = 0; g < 64; g++) begin : g_src
    if (g >= 1 && g <= NSOURCES) begin : g_gw
      plic_mt_gateway #(.EDGE(EDGE_MASK[g-1])) u_gw (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .src_i        (src_i[g-1]),
        .claim_clr    (claim_fire && claim_id == IDW'(g)),
        .complete_clr (cmp_fire && wdata_i[5:0] == 6'(g)),
        .pending_o    (pend_ids[g])
      );
    end else begin : g_none
      assign pend_ids[g] = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < 64; i++) prio8[i] = 8'(prio_q[i]);
  end

  for (genvar t = 0; t < NTARGETS; t++) begin : g_arb
    logic [63:0] elig;
    always_comb begin
      elig = '0;
      for (int i = 1; i <= NSOURCES; i++)
        elig[i] = pend_ids[i] & en_q[t][i] & (prio_q[i] > thr_q[t]);
    end
    assign best[t] = IDW'(best_id(elig, prio8));
  end

  always_comb begin
    rd       = req_i & ~we_i;
    wr       = req_i & we_i;
    prio_hit = 1'b0;
    en_hit   = '0;
    thr_hit  = '0;
    ctx_hit  = '0;
    rd_dat   = '0;
    claim_id = '0;
    eb       = '0;
    cb       = '0;
    if (addr_i[11:8] == PRIO_BASE[11:8] && addr_i[7:2] != 6'd0 && int'(addr_i[7:2]) <= NSOURCES) begin
      prio_hit = 1'b1;
      rd_dat   = 32'(prio_q[addr_i[7:2]]);
    end
    if (addr_i[11:8] == PEND_BASE[11:8] && addr_i[7:3] == 5'd0)
      rd_dat = addr_i[2] ? pend_ids[63:32] : pend_ids[31:0];
    for (int t = 0; t < NTARGETS; t++) begin
      eb = EN_BASE + EN_STRIDE * 12'(t);
      cb = CTX_BASE + CTX_STRIDE * 12'(t);
      if (addr_i[11:5] == eb[11:5] && addr_i[4:3] == 2'd0) begin
        en_hit[t] = 1'b1;
        rd_dat    = addr_i[2] ? en_q[t][63:32] : en_q[t][31:0];
      end
      if (addr_i[11:4] == cb[11:4] && addr_i[3:2] == 2'd0) begin
        thr_hit[t] = 1'b1;
        rd_dat     = 32'(thr_q[t]);
      end
      // Claim returns the arbiter's current choice; the same edge moves it to in-flight.
      if (addr_i[11:4] == cb[11:4] && addr_i[3:2] == 2'd1) begin
        ctx_hit[t] = 1'b1;
        rd_dat     = 32'(best[t]);
        claim_id   = best[t];
      end
    end
    claim_fire = rd & (|ctx_hit);
    cmp_fire   = wr & (|ctx_hit);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q    <= '0;
      en_q      <= '0;
      thr_q     <= '0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      ext_irq_o <= '0;
    end else begin
      rvalid_o <= req_i;
      rdata_o  <= rd ? rd_dat : 32'd0;
      if (wr && prio_hit) prio_q[addr_i[7:2]] <= wdata_i[PRIO_W-1:0];
      for (int t = 0; t < NTARGETS; t++) begin
        if (wr && en_hit[t]) begin
          if (addr_i[2]) en_q[t][63:32] <= wdata_i & ID_MASK[63:32];
          else           en_q[t][31:0]  <= wdata_i & ID_MASK[31:0];
        end
        if (wr && thr_hit[t]) thr_q[t] <= wdata_i[PRIO_W-1:0];
        ext_irq_o[t] <= (best[t] != '0);
      end
    end
  end

endmodule

// File: tb/tb_plic_mt.sv
// Directed bench for plic_mt: bus accesses, gateway behaviour, arbitration and reset.
// Drives inputs 1 time unit after each rising edge and samples outputs at the same point.
module tb_plic_mt;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] src_i;
  logic        req_i, we_i;
  logic [11:0] addr_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic [1:0]  ext_irq_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] r;

  plic_mt #(
    .NSOURCES (32),
    .NTARGETS (2),
    .PRIO_W   (3),
    .EDGE_MASK(32'h0000_0002)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .src_i    (src_i),
    .req_i    (req_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .ext_irq_o(ext_irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic bus(input logic we, input logic [11:0] a, input logic [31:0] d, output logic [31:0] rv);
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = a;
    wdata_i = d;
    @(posedge clk_i);
    #1;
    req_i   = 1'b0;
    we_i    = 1'b0;
    rv      = rdata_o;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic [31:0] rv;
    bus(1'b1, a, d, rv);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] rv;
    bus(1'b0, a, 32'd0, rv);
    chk(tag, rv, exp);
  endtask

  initial begin
    rst_i = 1'b1; src_i = '0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    idle(2);
    rst_i = 1'b0;
    chk("rst_irq", 32'(ext_irq_o), 32'd0);
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    rd_chk("rst_prio5", 12'h014, 32'd0);
    rd_chk("rst_en0", 12'h200, 32'd0);
    rd_chk("rst_thr1", 12'h410, 32'd0);
    rd_chk("rst_pend", 12'h100, 32'd0);

    // Single level pulse on ID 5
    wr(12'h014, 32'd3); wr(12'h200, 32'h20); wr(12'h400, 32'd0);
    src_i = 32'h10; idle(1); src_i = '0;
    chk("irq5_early", 32'(ext_irq_o[0]), 32'd0);
    rd_chk("pend5", 12'h100, 32'h20);
    chk("irq5_set", 32'(ext_irq_o[0]), 32'd1);
    rd_chk("claim5", 12'h404, 32'd5);
    chk("irq5_hold", 32'(ext_irq_o[0]), 32'd1);
    idle(1);
    chk("irq5_drop", 32'(ext_irq_o[0]), 32'd0);
    wr(12'h404, 32'd5);

    // Equal priority tie, then raised priority
    wr(12'h200, 32'h88); wr(12'h00C, 32'd2); wr(12'h01C, 32'd2);
    src_i = 32'h44; idle(1); src_i = '0;
    rd_chk("tie_a", 12'h404, 32'd3);
    rd_chk("tie_b", 12'h404, 32'd7);
    rd_chk("tie_c", 12'h404, 32'd0);
    wr(12'h404, 32'd3); wr(12'h404, 32'd7);
    wr(12'h01C, 32'd4);
    src_i = 32'h44; idle(1); src_i = '0;
    rd_chk("prio_a", 12'h404, 32'd7);
    rd_chk("prio_b", 12'h404, 32'd3);
    wr(12'h404, 32'd7); wr(12'h404, 32'd3);

    // Threshold on target 1
    wr(12'h410, 32'd3); wr(12'h024, 32'd3); wr(12'h220, 32'h200);
    src_i = 32'h100; idle(1); src_i = '0;
    idle(2);
    chk("thr_block", 32'(ext_irq_o[1]), 32'd0);
    rd_chk("thr_pend", 12'h100, 32'h200);
    wr(12'h410, 32'd2);
    chk("thr_lat", 32'(ext_irq_o[1]), 32'd0);
    idle(1);
    chk("thr_open", 32'(ext_irq_o[1]), 32'd1);
    chk("thr_t0", 32'(ext_irq_o[0]), 32'd0);
    rd_chk("claim9", 12'h414, 32'd9);
    wr(12'h414, 32'd9);

    // Edge source ID 2
    wr(12'h008, 32'd1); wr(12'h200, 32'h4);
    src_i = 32'h2; idle(1);
    rd_chk("claim2", 12'h404, 32'd2);
    for (int i = 0; i < 3; i++) begin
      src_i = '0; idle(1);
      src_i = 32'h2; idle(1);
    end
    src_i = '0; idle(2);
    rd_chk("edge_drop", 12'h100, 32'd0);
    chk("edge_irq", 32'(ext_irq_o[0]), 32'd0);
    wr(12'h404, 32'd2);
    idle(3);
    rd_chk("edge_quiet", 12'h100, 32'd0);
    chk("edge_quiet_irq", 32'(ext_irq_o[0]), 32'd0);
    src_i = 32'h2; idle(1);
    rd_chk("edge_new", 12'h100, 32'h4);
    rd_chk("claim2b", 12'h404, 32'd2);
    src_i = '0;
    wr(12'h404, 32'd2);

    // Level ID 4 held high
    wr(12'h010, 32'd1); wr(12'h200, 32'h10);
    src_i = 32'h8; idle(1);
    rd_chk("claim4", 12'h404, 32'd4);
    idle(2);
    chk("lvl_irq_off", 32'(ext_irq_o[0]), 32'd0);
    rd_chk("lvl_inflight", 12'h100, 32'd0);
    wr(12'h404, 32'd4);
    idle(1);
    rd_chk("lvl_repend", 12'h100, 32'h10);
    chk("lvl_irq_on", 32'(ext_irq_o[0]), 32'd1);
    wr(12'h404, 32'd4);
    rd_chk("lvl_noop", 12'h100, 32'h10);
    chk("lvl_noop_irq", 32'(ext_irq_o[0]), 32'd1);
    rd_chk("claim4b", 12'h404, 32'd4);
    src_i = '0;
    wr(12'h404, 32'd4);
    idle(1);
    rd_chk("lvl_done", 12'h100, 32'd0);

    // Address map boundaries
    rd_chk("unm_prio63", 12'h0FC, 32'd0);
    rd_chk("unm_pend2", 12'h108, 32'd0);
    rd_chk("unm_600", 12'h600, 32'd0);
    wr(12'h000, 32'd7);
    rd_chk("prio0", 12'h000, 32'd0);
    wr(12'h014, 32'hFF);
    rd_chk("prio_trunc", 12'h014, 32'd7);
    wr(12'h080, 32'd5);
    rd_chk("prio32", 12'h080, 32'd5);
    rd_chk("prio33", 12'h084, 32'd0);
    bus(1'b1, 12'h200, 32'hFFFF_FFFF, r);
    chk("wr_rdata", r, 32'd0);
    chk("wr_rvalid", 32'(rvalid_o), 32'd1);
    rd_chk("en_w0", 12'h200, 32'hFFFF_FFFE);
    wr(12'h204, 32'hFFFF_FFFF);
    rd_chk("en_w1", 12'h204, 32'h1);
    wr(12'h204, 32'd0);

    // Async reset in the middle of a claim
    wr(12'h200, 32'h28);
    src_i = 32'h14; idle(1); src_i = '0;
    rd_chk("claim5b", 12'h404, 32'd5);
    idle(1);
    chk("pre_rst_irq", 32'(ext_irq_o[0]), 32'd1);
    bus(1'b0, 12'h014, 32'd0, r);
    chk("pre_rst_rd", r, 32'd7);
    chk("pre_rst_rvalid", 32'(rvalid_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_irq", 32'(ext_irq_o), 32'd0);
    chk("arst_rvalid", 32'(rvalid_o), 32'd0);
    chk("arst_rdata", rdata_o, 32'd0);
    idle(2);
    rst_i = 1'b0;
    rd_chk("arst_prio5", 12'h014, 32'd0);
    rd_chk("arst_en0", 12'h200, 32'd0);
    rd_chk("arst_pend", 12'h100, 32'd0);
    wr(12'h014, 32'd1); wr(12'h200, 32'h20);
    src_i = 32'h10; idle(1); src_i = '0;
    rd_chk("arst_repend", 12'h100, 32'h20);
    rd_chk("arst_claim", 12'h404, 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
